// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential arithmetic unit: op encodings and FSM states.
package seq_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a controller (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 8
);

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [1:0]             ctrl;
  logic [2*WIDTH-1:0]     y;
  logic                   c;
  logic                   err;
  logic                   busy;
  logic                   done;

  modport master (
    output start, a, b, ctrl,
    input  y, c, err, busy, done
  );

  modport slave (
    input  start, a, b, ctrl,
    output y, c, err, busy, done
  );

endinterface

// File: rtl/seq_alu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module seq_alu_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
  always_comb begin
    shifted_s = {rem_in, dvd_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    q_bit     = ~diff_s[WIDTH];
    if (q_bit) begin
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, shift-add multiply and restoring
// divide behind a start/busy/done handshake.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e               state_r;
  state_e               state_s;

  logic [WIDTH-1:0]     op_a_r;
  logic [WIDTH-1:0]     op_b_r;
  logic [1:0]           ctrl_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     quo_r;

  logic [WIDTH-1:0]     step_rem_s;
  logic                 step_q_s;
  logic                 div_zero_s;
  logic                 cnt_zero_s;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       dif_s;
  logic [2*WIDTH-1:0]   y_s;
  logic                 c_s;
  logic                 err_s;
  logic                 fin_s;

  logic [2*WIDTH-1:0]   y_r;
  logic                 c_r;
  logic                 err_r;
  logic                 busy_r;
  logic                 done_r;

  assign div_zero_s = (op_b_r == {WIDTH{1'b0}});
  assign cnt_zero_s = (cnt_r == {CW{1'b0}});

  seq_alu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_r),
    .dvd_bit (quo_r[WIDTH-1]),
    .divisor (op_b_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; iteration states leave one edge after the counter reaches zero.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          case (bus.ctrl)
            OP_MUL:  state_s = MUL;
            OP_DIV:  state_s = DIV;
            default: state_s = ADDSUB;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ADDSUB: state_s = FIN;
      MUL: begin
        if (cnt_zero_s) begin
          state_s = FIN;
        end else begin
          state_s = MUL;
        end
      end
      DIV: begin
        if (div_zero_s || cnt_zero_s) begin
          state_s = FIN;
        end else begin
          state_s = DIV;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Result selection, committed to the output registers while leaving FIN.
  always_comb begin
    fin_s = (state_r == FIN);
    sum_s = {1'b0, op_a_r} + {1'b0, op_b_r};
    dif_s = {1'b0, op_a_r} - {1'b0, op_b_r};
    y_s   = {(2*WIDTH){1'b0}};
    c_s   = 1'b0;
    err_s = 1'b0;
    case (ctrl_r)
      OP_ADD: begin
        y_s = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
        c_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        y_s = {{WIDTH{1'b0}}, dif_s[WIDTH-1:0]};
        c_s = dif_s[WIDTH];
      end
      OP_MUL: begin
        y_s = prod_r;
      end
      OP_DIV: begin
        if (div_zero_s) begin
          y_s   = {op_a_r, {WIDTH{1'b1}}};
          err_s = 1'b1;
        end else begin
          y_s   = {rem_r, quo_r};
          err_s = 1'b0;
        end
      end
      default: begin
        y_s = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // Operand capture and the per-iteration multiply / divide datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      ctrl_r   <= OP_ADD;
      cnt_r    <= {CW{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_a_r   <= bus.a;
            op_b_r   <= bus.b;
            ctrl_r   <= bus.ctrl;
            cnt_r    <= CNT_INIT;
            prod_r   <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, bus.a};
            mplier_r <= bus.b;
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= bus.a;
          end
        end
        MUL: begin
          if (!cnt_zero_s) begin
            if (mplier_r[0]) begin
              prod_r <= prod_r + mcand_r;
            end
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_ONE;
          end
        end
        DIV: begin
          // quo_r starts as the dividend; quotient bits shift in as dividend bits shift out.
          if (!div_zero_s && !cnt_zero_s) begin
            rem_r <= step_rem_s;
            quo_r <= {quo_r[WIDTH-2:0], step_q_s};
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r    <= {(2*WIDTH){1'b0}};
      c_r    <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= fin_s;
      if (fin_s) begin
        y_r   <= y_s;
        c_r   <= c_s;
        err_r <= err_s;
      end
    end
  end

  assign bus.y    = y_r;
  assign bus.c    = c_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
